stats_req_parser: RTL and testbench

Converts the byte stream that stats clients send over TCP into `requester_input` commands for the stats requester. Each 2-byte `tracker_req_pkt` (x_coord, y_coord) becomes one command that directs the tracker to stream the next chunk of its log to tile (x, y). A read cursor advances by one chunk per command, so a client walks the tracker log with repeated requests. It sits between the app RX data path and the requester.

---
 rtl/stats_manager_pkg.sv | 32 +++
 rtl/stats_req_cursor.sv | 49 ++++
 rtl/stats_req_parser.sv | 115 +++++++++++
 tb/tb_stats_req_parser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stats_manager_pkg.sv
// stats_manager_pkg: shared tracker/requester types and the stats request parser FSM encoding
package stats_manager_pkg;

    localparam int TRACKER_ADDR_W = 10;
    localparam int COORD_W        = 10;
    localparam int FBITS_W        = 4;

    localparam logic [FBITS_W-1:0] TRACKER_FBITS = 4'h5;

    typedef enum logic [1:0] {
        TRACKER_REQ_READ  = 2'd0,
        TRACKER_REQ_STATS = 2'd1,
        TRACKER_REQ_CLEAR = 2'd2
    } tracker_req_type;

    localparam tracker_req_type STATS_REQ_TYPE = TRACKER_REQ_STATS;

    typedef struct packed {
        tracker_req_type             req_type;
        logic [COORD_W-1:0]          dst_x;
        logic [COORD_W-1:0]          dst_y;
        logic [FBITS_W-1:0]          dst_fbits;
        logic [TRACKER_ADDR_W-1:0]   start_addr;
        logic [TRACKER_ADDR_W-1:0]   end_addr;
    } requester_input;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } stats_req_parser_state_e;

endpackage

// File: rtl/stats_req_cursor.sv
// stats_req_cursor: tracker log read cursor and chunk end-address clamp; STATS_REQ_PARSER_WRAP_EN wraps to 0 at the log end, otherwise saturates
module stats_req_cursor
    import stats_manager_pkg::*;
#(
    parameter int CHUNK_ENTRIES = 64,
    parameter int ADDR_LIMIT    = 2**TRACKER_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      adv_i,
    output logic [TRACKER_ADDR_W-1:0] cursor_o,
    output logic [TRACKER_ADDR_W-1:0] end_addr_o
);
    localparam int W = TRACKER_ADDR_W + 1;
    localparam logic [W-1:0] CHUNK_M1 = W'(CHUNK_ENTRIES - 1);
    localparam logic [W-1:0] LAST     = W'(ADDR_LIMIT - 1);
`ifdef STATS_REQ_PARSER_WRAP_EN
    localparam logic [TRACKER_ADDR_W-1:0] AT_END = '0;
`else
    localparam logic [TRACKER_ADDR_W-1:0] AT_END = TRACKER_ADDR_W'(ADDR_LIMIT - 1);
`endif

    logic [TRACKER_ADDR_W-1:0] cursor_q, cursor_d;
    logic [W-1:0]              sum, end_w;

    // Chunk end computed one bit wider so the sum cannot overflow before the clamp
    always_comb begin
        sum   = {1'b0, cursor_q} + CHUNK_M1;
        end_w = (sum > LAST) ? LAST : sum;
    end

    // Step past the issued chunk; a clear overrides a simultaneous advance
    always_comb begin
        cursor_d = clr_i ? '0 :
                   !adv_i ? cursor_q :
                   (end_w == LAST) ? AT_END : TRACKER_ADDR_W'(end_w + W'(1));
    end

    // Cursor register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cursor_q <= '0;
        else        cursor_q <= cursor_d;
    end

    assign cursor_o   = cursor_q;
    assign end_addr_o = TRACKER_ADDR_W'(end_w);

endmodule

// File: rtl/stats_req_parser.sv
// stats_req_parser: turns 2-byte (x, y) request packets from the RX byte stream into requester commands that walk the tracker log
module stats_req_parser
    import stats_manager_pkg::*;
#(
    parameter int IN_BYTES      = 8,
    parameter int CHUNK_ENTRIES = 64,
    parameter int ADDR_LIMIT    = 2**TRACKER_ADDR_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx_req_val,
    input  logic [IN_BYTES*8-1:0]           rx_req_data,
    input  logic [$clog2(IN_BYTES+1)-1:0]   rx_req_bytes,
    output logic                            rx_req_rdy,
    input  logic                            cursor_clr,
    output logic                            req_val,
    output requester_input                  req_data,
    input  logic                            req_rdy,
    output logic [TRACKER_ADDR_W-1:0]       cursor
);
    localparam int W  = IN_BYTES * 8;
    localparam int BW = $clog2(IN_BYTES + 1);

    stats_req_parser_state_e   state_q, state_d;
    logic [W-1:0]              data_q, data_d;
    logic [BW-1:0]             rem_q, rem_d;
    logic [7:0]                carry_q, carry_d;
    logic                      carry_vld_q, carry_vld_d;
    logic                      req_val_q, req_val_d;
    requester_input            req_data_q, req_data_d;
    logic [7:0]                b0, b1, x, y;
    logic                      has_cmd, fire;
    logic [TRACKER_ADDR_W-1:0] end_addr;

    stats_req_cursor #(
        .CHUNK_ENTRIES (CHUNK_ENTRIES),
        .ADDR_LIMIT    (ADDR_LIMIT)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cursor_clr),
        .adv_i      (fire),
        .cursor_o   (cursor),
        .end_addr_o (end_addr)
    );

    // Held bytes are kept left-aligned so the next packet always sits in the top two bytes
    assign b0      = data_q[W-1 -: 8];
    assign b1      = data_q[W-9 -: 8];
    assign x       = carry_vld_q ? carry_q : b0;
    assign y       = carry_vld_q ? b0 : b1;
    assign has_cmd = carry_vld_q ? (rem_q != '0) : (rem_q >= BW'(2));
    assign fire    = (state_q == DRAIN) && has_cmd && (!req_val_q || req_rdy);

    assign rx_req_rdy = rst_n && (state_q == IDLE);
    assign req_val    = req_val_q;
    assign req_data   = req_data_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            carry_q     <= '0;
            carry_vld_q <= 1'b0;
            req_val_q   <= 1'b0;
            req_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            carry_vld_q <= carry_vld_d;
            req_val_q   <= req_val_d;
            req_data_q  <= req_data_d;
        end
    end

    // Leave DRAIN as soon as fewer than two usable bytes remain
    always_comb begin
        state_d = (state_q == IDLE) ? (rx_req_val ? DRAIN : IDLE) : (has_cmd ? DRAIN : IDLE);
    end

    // Beat capture, packet extraction, carry handling and output register load
    always_comb begin
        data_d      = data_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        carry_vld_d = carry_vld_q;
        req_val_d   = req_val_q && !req_rdy;
        req_data_d  = req_data_q;
        if (state_q == IDLE && rx_req_val) begin
            data_d = rx_req_data;
            rem_d  = rx_req_bytes;
        end
        if (fire) begin
            data_d                = data_q << (carry_vld_q ? 8 : 16);
            rem_d                 = rem_q - (carry_vld_q ? BW'(1) : BW'(2));
            carry_vld_d           = 1'b0;
            req_val_d             = 1'b1;
            req_data_d.req_type   = STATS_REQ_TYPE;
            req_data_d.dst_x      = COORD_W'(x);
            req_data_d.dst_y      = COORD_W'(y);
            req_data_d.dst_fbits  = TRACKER_FBITS;
            req_data_d.start_addr = cursor;
            req_data_d.end_addr   = end_addr;
        end
        if (state_q == DRAIN && !carry_vld_q && rem_q == BW'(1)) begin
            carry_d     = b0;
            carry_vld_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_stats_req_parser.sv
// tb_stats_req_parser: directed checks of packet parsing, carry, stall, cursor clear, reset and log-end behaviour
module tb_stats_req_parser;
    import stats_manager_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    logic                      a_rx_val = 1'b0;
    logic [63:0]               a_rx_data = '0;
    logic [3:0]                a_rx_bytes = '0;
    logic                      a_rx_rdy;
    logic                      a_clr = 1'b0;
    logic                      a_val;
    requester_input            a_data;
    logic                      a_rdy = 1'b1;
    logic [TRACKER_ADDR_W-1:0] a_cursor;

    logic                      b_rx_val = 1'b0;
    logic [63:0]               b_rx_data = '0;
    logic [3:0]                b_rx_bytes = '0;
    logic                      b_rx_rdy;
    logic                      b_clr = 1'b0;
    logic                      b_val;
    requester_input            b_data;
    logic                      b_rdy = 1'b1;
    logic [TRACKER_ADDR_W-1:0] b_cursor;

    always #5 clk = ~clk;

    stats_req_parser dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_req_val   (a_rx_val),
        .rx_req_data  (a_rx_data),
        .rx_req_bytes (a_rx_bytes),
        .rx_req_rdy   (a_rx_rdy),
        .cursor_clr   (a_clr),
        .req_val      (a_val),
        .req_data     (a_data),
        .req_rdy      (a_rdy),
        .cursor       (a_cursor)
    );

    stats_req_parser #(.ADDR_LIMIT(100)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_req_val   (b_rx_val),
        .rx_req_data  (b_rx_data),
        .rx_req_bytes (b_rx_bytes),
        .rx_req_rdy   (b_rx_rdy),
        .cursor_clr   (b_clr),
        .req_val      (b_val),
        .req_data     (b_data),
        .req_rdy      (b_rdy),
        .cursor       (b_cursor)
    );

    function automatic requester_input cmd(input int x, input int y, input int s, input int e);
        requester_input c;
        c.req_type   = STATS_REQ_TYPE;
        c.dst_x      = COORD_W'(x);
        c.dst_y      = COORD_W'(y);
        c.dst_fbits  = TRACKER_FBITS;
        c.start_addr = TRACKER_ADDR_W'(s);
        c.end_addr   = TRACKER_ADDR_W'(e);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [63:0] d, input int n);
        a_rx_val   = 1'b1;
        a_rx_data  = d;
        a_rx_bytes = 4'(n);
        tick();
        a_rx_val   = 1'b0;
    endtask

    initial begin
        requester_input held;
        // reset state
        tick();
        tick();
        chk("rst_req_val", 64'(a_val), 64'd0);
        chk("rst_rx_rdy", 64'(a_rx_rdy), 64'd0);
        chk("rst_cursor", 64'(a_cursor), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rx_rdy", 64'(a_rx_rdy), 64'd1);

        // single 2-byte request
        beat_a(64'h0301_0000_0000_0000, 2);
        chk("t1_no_val_yet", 64'(a_val), 64'd0);
        tick();
        chk("t1_val", 64'(a_val), 64'd1);
        chk("t1_cmd", 64'(a_data), 64'(cmd(3, 1, 0, 63)));
        chk("t1_cursor", 64'(a_cursor), 64'd64);
        tick();
        chk("t1_done_val", 64'(a_val), 64'd0);
        chk("t1_done_rdy", 64'(a_rx_rdy), 64'd1);

        // clear, then a 6-byte beat
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_cursor", 64'(a_cursor), 64'd0);
        beat_a(64'h0102_0304_0506_0000, 6);
        tick();
        chk("t2_cmd0", 64'(a_data), 64'(cmd(1, 2, 0, 63)));
        tick();
        chk("t2_cmd1", 64'(a_data), 64'(cmd(3, 4, 64, 127)));
        tick();
        chk("t2_cmd2", 64'(a_data), 64'(cmd(5, 6, 128, 191)));
        chk("t2_busy_rdy", 64'(a_rx_rdy), 64'd0);
        tick();
        chk("t2_done_val", 64'(a_val), 64'd0);
        chk("t2_done_rdy", 64'(a_rx_rdy), 64'd1);
        chk("t2_cursor", 64'(a_cursor), 64'd192);

        // split request across beats, with an empty beat in between
        beat_a(64'h0102_0700_0000_0000, 3);
        tick();
        chk("t3_cmd0", 64'(a_data), 64'(cmd(1, 2, 192, 255)));
        tick();
        chk("t3_carry_val", 64'(a_val), 64'd0);
        chk("t3_carry_rdy", 64'(a_rx_rdy), 64'd1);
        beat_a(64'h0, 0);
        tick();
        chk("t3_empty_val", 64'(a_val), 64'd0);
        chk("t3_empty_rdy", 64'(a_rx_rdy), 64'd1);
        beat_a(64'h0900_0000_0000_0000, 1);
        tick();
        chk("t3_cmd1", 64'(a_data), 64'(cmd(7, 9, 256, 319)));
        chk("t3_cmd1_val", 64'(a_val), 64'd1);
        tick();
        beat_a(64'h0506_0000_0000_0000, 2);
        tick();
        chk("t3_carry_gone", 64'(a_data), 64'(cmd(5, 6, 320, 383)));
        tick();

        // output stall
        a_rdy = 1'b0;
        beat_a(64'h0A0B_0C0D_0000_0000, 4);
        tick();
        held = cmd(10, 11, 384, 447);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", 64'(a_data), 64'(held));
            chk("stall_cursor", 64'(a_cursor), 64'd448);
        end
        chk("stall_val", 64'(a_val), 64'd1);
        a_rdy = 1'b1;
        tick();
        chk("stall_next", 64'(a_data), 64'(cmd(12, 13, 448, 511)));
        tick();

        // clear coinciding with a handshake
        beat_a(64'h1122_3344_0000_0000, 4);
        tick();
        chk("clrhs_cmd0", 64'(a_data), 64'(cmd(8'h11, 8'h22, 512, 575)));
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clrhs_cursor", 64'(a_cursor), 64'd0);
        chk("clrhs_cmd1", 64'(a_data), 64'(cmd(8'h33, 8'h44, 576, 639)));
        tick();

        // reset mid-beat discards carry and held bytes
        beat_a(64'h7700_0000_0000_0000, 1);
        tick();
        beat_a(64'h0102_0304_0506_0000, 6);
        tick();
        chk("pre_rst_cmd", 64'(a_data), 64'(cmd(8'h77, 1, 0, 63)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 64'(a_val), 64'd0);
        chk("mid_rst_rdy", 64'(a_rx_rdy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_val", 64'(a_val), 64'd0);
        chk("post_rst_cursor", 64'(a_cursor), 64'd0);
        beat_a(64'h2122_0000_0000_0000, 2);
        tick();
        chk("post_rst_cmd", 64'(a_data), 64'(cmd(8'h21, 8'h22, 0, 63)));
        tick();

        // log end with ADDR_LIMIT=100
        b_rx_val   = 1'b1;
        b_rx_data  = 64'h0102_0304_0506_0000;
        b_rx_bytes = 4'd6;
        tick();
        b_rx_val   = 1'b0;
        tick();
        chk("lim_cmd0", 64'(b_data), 64'(cmd(1, 2, 0, 63)));
        tick();
        chk("lim_cmd1", 64'(b_data), 64'(cmd(3, 4, 64, 99)));
        tick();
`ifdef STATS_REQ_PARSER_WRAP_EN
        chk("lim_cmd2_wrap", 64'(b_data), 64'(cmd(5, 6, 0, 63)));
`else
        chk("lim_cmd2_sat", 64'(b_data), 64'(cmd(5, 6, 99, 99)));
        chk("lim_cursor_sat", 64'(b_cursor), 64'd99);
`endif
        tick();
        chk("lim_done_rdy", 64'(b_rx_rdy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
